operand_fetch_unit: RTL and testbench

Sequencer that drives the CPU data bus from program memory: it fetches the opcode byte, then, for two-byte instructions, the operand byte, and loads each into the instruction register and the operand register with one-cycle load strobes. It sits between program memory and the instruction and operand registers, and owns the fetch address counter. The control unit starts each fetch and is told when the instruction is complete.

---
 rtl/operand_fetch_unit.sv | 88 ++++++++
 tb/tb_operand_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: fetches opcode and optional operand byte from program memory into IR/OR
module operand_fetch_unit #(
  parameter logic [1:0] IMM_PREFIX = 2'b11,
  parameter int         ADDR_W     = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [7:0]        mem_data,
  output logic [7:0]        dataBusOut,
  output logic              L_IR,
  output logic              L_OR,
  output logic              busy,
  output logic              fetch_done,
  output logic              has_operand
);
  typedef enum logic [2:0] {IDLE, RD_OP, LD_OP, RD_IMM, LD_IMM, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              has_q, has_d;
  logic              rd_q, ir_q, or_q, busy_q, done_q;
  assign mem_addr    = cnt_q;
  assign dataBusOut  = hold_q;
  assign mem_rd      = rd_q;
  assign L_IR        = ir_q;
  assign L_OR        = or_q;
  assign busy        = busy_q;
  assign fetch_done  = done_q;
  assign has_operand = has_q;
  // next state: a jump load in IDLE wins over start; each ready read captures a byte and bumps the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    has_d   = has_q;
    case (state_q)
      IDLE: begin
        if (pc_load) cnt_d = pc_in;
        else if (start) state_d = RD_OP;
      end
      RD_OP: if (mem_ready) begin
        hold_d  = mem_data;
        cnt_d   = cnt_q + ADDR_W'(1);
        has_d   = mem_data[7:6] == IMM_PREFIX;
        state_d = LD_OP;
      end
      LD_OP:  state_d = has_q ? RD_IMM : DONE;
      RD_IMM: if (mem_ready) begin
        hold_d  = mem_data;
        cnt_d   = cnt_q + ADDR_W'(1);
        state_d = LD_IMM;
      end
      LD_IMM:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs decoded from the state being entered, so strobes line up with their state
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      has_q   <= 1'b0;
      rd_q    <= 1'b0;
      ir_q    <= 1'b0;
      or_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      has_q   <= has_d;
      rd_q    <= state_d == RD_OP || state_d == RD_IMM;
      ir_q    <= state_d == LD_OP;
      or_q    <= state_d == LD_IMM;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: randomized fetches against a cycle-count model of the fetch sequencer
module tb_operand_fetch_unit;
  logic       CLK = 1'b0;
  logic       RSTn, start, pc_load, mem_ready;
  logic [7:0] pc_in, mem_addr, mem_data, dataBusOut;
  logic       mem_rd, L_IR, L_OR, busy, fetch_done, has_operand;
  logic [7:0] mem [256];
  logic [7:0] pc;
  int         n_chk = 0, n_pass = 0;

  operand_fetch_unit dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .pc_load(pc_load), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_data(mem_data),
    .dataBusOut(dataBusOut), .L_IR(L_IR), .L_OR(L_OR), .busy(busy),
    .fetch_done(fetch_done), .has_operand(has_operand)
  );

  always #5 CLK = ~CLK;
  assign mem_data = mem[mem_addr];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_pc(input logic [7:0] v);
    pc_load = 1'b1;
    pc_in = v;
    @(posedge CLK);
    #1 pc_load = 1'b0;
    pc = v;
    chk("pc_load", mem_addr, v);
  endtask

  task automatic fetch(input int w1, input int w2, input bit rep);
    logic [7:0] op, imm, pa1, ir_b, or_b;
    bit two, busy_ok;
    int cyc, wc, ir_c, or_c, dn_c, both;
    pa1 = pc + 8'd1;
    op = mem[pc];
    imm = mem[pa1];
    two = op[7:6] == 2'b11;
    ir_c = -1; or_c = -1; dn_c = -1; both = 0; ir_b = 0; or_b = 0; busy_ok = 1; wc = w1;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    cyc = 1;
    while (dn_c < 0 && cyc <= 40) begin
      if (!busy) busy_ok = 0;
      if (L_IR && L_OR) both++;
      if (L_IR) begin ir_c = cyc; ir_b = dataBusOut; wc = w2; end
      if (L_OR) begin or_c = cyc; or_b = dataBusOut; end
      if (fetch_done) dn_c = cyc;
      if (mem_rd) begin
        mem_ready = wc == 0;
        if (wc > 0) wc--;
      end else mem_ready = 1'($urandom);
      start = rep && cyc == 2;
      if (dn_c < 0) begin
        @(posedge CLK);
        #1 cyc++;
      end
    end
    start = 1'b0;
    chk("ir_cycle", ir_c, 2 + w1);
    chk("ir_byte", ir_b, op);
    chk("or_cycle", or_c, two ? 4 + w1 + w2 : -1);
    if (two) chk("or_byte", or_b, imm);
    chk("done_cycle", dn_c, two ? 5 + w1 + w2 : 3 + w1);
    chk("strobe_overlap", both, 0);
    chk("busy_span", busy_ok, 1);
    chk("has_operand", has_operand, two);
    pc = pc + (two ? 8'd2 : 8'd1);
    chk("counter", mem_addr, pc);
    @(posedge CLK);
    #1 chk("idle_after", busy, 0);
  endtask

  initial begin
    int k, seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    RSTn = 1'b0; start = 1'b0; pc_load = 1'b0; pc_in = 8'h00; mem_ready = 1'b0; pc = 8'h00;
    repeat (3) @(posedge CLK);
    #1 chk("rst_flags", {mem_rd, L_IR, L_OR, busy, fetch_done, has_operand}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_bus", dataBusOut, 0);
    @(negedge CLK) RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      @(posedge CLK);
      #1 chk("idle_stay", {mem_rd, L_IR, L_OR, busy, fetch_done}, 0);
    end
    mem[8'h10] = 8'h25;
    load_pc(8'h10);
    fetch(0, 0, 0);
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h7A;
    load_pc(8'h20);
    fetch(2, 2, 0);
    mem[8'hFF] = 8'hC0;
    mem[8'h00] = 8'h5A;
    load_pc(8'hFF);
    fetch(0, 1, 0);
    pc_load = 1'b1; pc_in = 8'h40; start = 1'b1;
    @(posedge CLK);
    #1 pc_load = 1'b0; start = 1'b0; pc = 8'h40;
    chk("load_wins_pc", mem_addr, 8'h40);
    chk("load_wins_idle", busy, 0);
    @(posedge CLK);
    #1 chk("load_wins_stay", {busy, mem_rd}, 0);
    fetch(1, 0, 1);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(2) == 0) load_pc(8'($urandom));
      fetch(int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom));
    end
    mem[8'h30] = 8'hC5;
    load_pc(8'h30);
    start = 1'b1;
    mem_ready = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    k = 0;
    while (!L_IR && k < 10) begin
      @(posedge CLK);
      #1 k++;
    end
    chk("abort_ir", L_IR, 1);
    mem_ready = 1'b0;
    @(posedge CLK);
    #1 chk("abort_in_rd", mem_rd, 1);
    #2 RSTn = 1'b0;
    #1 chk("abort_flags", {mem_rd, L_IR, L_OR, busy, fetch_done}, 0);
    chk("abort_addr", mem_addr, 0);
    @(negedge CLK) RSTn = 1'b1;
    mem_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1 seen += int'(L_OR) + int'(fetch_done) + int'(L_IR) + int'(busy);
    end
    chk("abort_quiet", seen, 0);
    chk("abort_counter", mem_addr, 0);
    pc = 8'h00;
    fetch(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
